// File: rtl/aes128_sub_bytes_lanes_if.sv
// Output beat stream of the multi-lane SubBytes engine: one beat of LANES
// substituted bytes plus the index of its first byte, with ready backpressure.
interface aes128_sub_bytes_lanes_if #(
  parameter int unsigned N_BYTES = 16,
  parameter int unsigned LANES   = 4
);
  localparam int unsigned AW = $clog2(N_BYTES);

  logic              valid_o;
  logic              ready_i;
  logic [LANES*8-1:0] data_o;
  logic [AW-1:0]     addr_o;

  // Engine side drives the beat, consumer side drives ready.
  modport master (
    output valid_o,
    output data_o,
    output addr_o,
    input  ready_i
  );

  modport slave (
    input  valid_o,
    input  data_o,
    input  addr_o,
    output ready_i
  );
endinterface

// File: rtl/aes128_sub_bytes_lanes.sv
// Multi-lane AES SubBytes engine. Snapshots a full state on start and streams
// S-box substituted bytes, LANES per beat, with backpressure and abort.
// Optional build macro AES128_SUB_BYTES_EXT_SBOX_EN moves the S-box outside
// the block through the sbox_sub_o/sbox_sub_i ports.
package aes128_type_pkg;
  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;
endpackage

// Single-byte Rijndael S-box, forward or inverse, computed as GF(2^8)
// inversion combined with the affine transform.
module aes128_rijndael_sbox (
  input  logic       inv_i,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 = product of x^(2^i) for i = 1..7; maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Select forward or inverse substitution.
  always_comb begin
    if (inv_i) byte_o = gf_inv(aff_inv(byte_i));
    else       byte_o = aff_fwd(gf_inv(byte_i));
  end
endmodule

module aes128_sub_bytes_lanes #(
  parameter int unsigned N_BYTES = 16,
  parameter int unsigned LANES   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  aes128_type_pkg::mode_t mode_i,
  input  logic [N_BYTES*8-1:0]  data_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  aes128_sub_bytes_lanes_if.master out_if
`ifdef AES128_SUB_BYTES_EXT_SBOX_EN
  ,
  output logic [LANES*8-1:0]    sbox_sub_o,
  input  logic [LANES*8-1:0]    sbox_sub_i
`endif
);
  localparam int unsigned BEATS = N_BYTES / LANES;
  localparam int unsigned AW    = $clog2(N_BYTES);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW    = LANES * 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_OUTPUT = 1'b1;

  logic [0:0]             state_q;
  logic [N_BYTES*8-1:0]   snap_q;
  aes128_type_pkg::mode_t mode_q;
  logic [BW-1:0]          beat_q;
  logic                   done_q;

  logic                   in_output;
  logic                   xfer;
  logic                   last_beat;
  logic [DW-1:0]          lane_vec;
  logic [DW-1:0]          sub_res;

  assign in_output = (state_q == ST_OUTPUT);
  assign xfer      = in_output && out_if.ready_i;
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // Capture on start, advance on each accepted beat, abort wins over a
  // coincident final transfer so no done is raised in that case.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      mode_q  <= aes128_type_pkg::MODE_ENC;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            snap_q  <= data_i;
            mode_q  <= mode_i;
            beat_q  <= '0;
            state_q <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
          end else if (xfer) begin
            if (last_beat) begin
              state_q <= ST_IDLE;
              beat_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bytes of the current beat taken from the snapshot; zero while idle.
  always_comb begin
    lane_vec = DW'(snap_q >> (DW * 32'(beat_q)));
    if (!in_output) lane_vec = '0;
  end

`ifdef AES128_SUB_BYTES_EXT_SBOX_EN
  logic unused_mode;
  assign unused_mode = mode_q;
  assign sbox_sub_o  = lane_vec;
  assign sub_res     = sbox_sub_i;
`else
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    aes128_rijndael_sbox u_sbox (
      .inv_i  (mode_q == aes128_type_pkg::MODE_DEC),
      .byte_i (lane_vec[8*j +: 8]),
      .byte_o (sub_res[8*j +: 8])
    );
  end
`endif

  // Beat outputs, forced to zero outside OUTPUT (S(0) is not zero).
  always_comb begin
    out_if.valid_o = in_output;
    out_if.data_o  = in_output ? sub_res : '0;
    out_if.addr_o  = in_output ? AW'(32'(beat_q) * LANES) : '0;
  end

  assign busy_o = in_output;
  assign done_o = done_q;
endmodule

// File: tb/tb_aes128_sub_bytes_lanes.sv
// Bench for aes128_sub_bytes_lanes: three configurations (LANES 4, 16, 8),
// a beat-level reference model and directed FIPS-197 vectors.
module tb_aes128_sub_bytes_lanes;
  import aes128_type_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0]   start_v = '0;
  logic [2:0]   abort_v = '0;
  logic [2:0]   ready_v = '0;
  mode_t        mode_v [3];
  logic [127:0] din_v  [3];

  wire  [2:0]   busy_w;
  wire  [2:0]   done_w;
  wire  [2:0]   valid_w;
  wire  [127:0] data_w [3];
  wire  [3:0]   addr_w [3];

  aes128_sub_bytes_lanes_if #(.N_BYTES(16), .LANES(4))  if_a ();
  aes128_sub_bytes_lanes_if #(.N_BYTES(16), .LANES(16)) if_b ();
  aes128_sub_bytes_lanes_if #(.N_BYTES(16), .LANES(8))  if_c ();

  aes128_sub_bytes_lanes #(.N_BYTES(16), .LANES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_v[0]), .data_i(din_v[0]),
    .start_i(start_v[0]), .abort_i(abort_v[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .out_if(if_a.master));
  aes128_sub_bytes_lanes #(.N_BYTES(16), .LANES(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_v[1]), .data_i(din_v[1]),
    .start_i(start_v[1]), .abort_i(abort_v[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .out_if(if_b.master));
  aes128_sub_bytes_lanes #(.N_BYTES(16), .LANES(8)) dut_c (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_v[2]), .data_i(din_v[2]),
    .start_i(start_v[2]), .abort_i(abort_v[2]), .busy_o(busy_w[2]),
    .done_o(done_w[2]), .out_if(if_c.master));

  assign if_a.ready_i = ready_v[0];
  assign if_b.ready_i = ready_v[1];
  assign if_c.ready_i = ready_v[2];
  assign valid_w[0] = if_a.valid_o;
  assign valid_w[1] = if_b.valid_o;
  assign valid_w[2] = if_c.valid_o;
  assign data_w[0]  = 128'(if_a.data_o);
  assign data_w[1]  = 128'(if_b.data_o);
  assign data_w[2]  = 128'(if_c.data_o);
  assign addr_w[0]  = if_a.addr_o;
  assign addr_w[1]  = if_b.addr_o;
  assign addr_w[2]  = if_c.addr_o;

  // ---------------- reference S-box tables ----------------
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned x, y, p;
    x = a; y = b; p = 0;
    while (y != 0) begin
      if (y % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x >= 256) x = x ^ 32'h11b;
      y = y / 2;
    end
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      fwd_tab[x] = b;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [127:0] subst(input logic [127:0] s, input mode_t m);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = (m == MODE_DEC) ? inv_tab[s[8*k +: 8]] : fwd_tab[s[8*k +: 8]];
    return r;
  endfunction

  function automatic int unsigned lanes_of(input int k);
    case (k)
      0: return 4;
      1: return 16;
      default: return 8;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- beat-level model ----------------
  logic         armed = 1'b0;
  logic [2:0]   m_active = '0;
  logic [2:0]   m_done = '0;
  int unsigned  m_beat [3];
  logic [127:0] m_state [3];

  // Model tracks which substituted beat is owed and whether done is due.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      m_done[k] <= 1'b0;
      if (rst) begin
        m_active[k] <= 1'b0;
        m_beat[k]   <= 0;
      end else if (m_active[k]) begin
        if (abort_v[k]) m_active[k] <= 1'b0;
        else if (ready_v[k]) begin
          if (m_beat[k] == 16 / lanes_of(k) - 1) begin
            m_active[k] <= 1'b0;
            m_done[k]   <= 1'b1;
          end else m_beat[k] <= m_beat[k] + 1;
        end
      end else if (start_v[k] && !abort_v[k]) begin
        m_active[k] <= 1'b1;
        m_beat[k]   <= 0;
        m_state[k]  <= subst(din_v[k], mode_v[k]);
      end
    end
    if (rst) armed <= 1'b1;
  end

  // Compare every DUT against the model each cycle.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        logic [127:0] mask, ed;
        logic [3:0]   ea;
        mask = {128{1'b1}} >> (128 - lanes_of(k) * 8);
        ed = m_active[k] ? ((m_state[k] >> (m_beat[k] * lanes_of(k) * 8)) & mask) : '0;
        ea = m_active[k] ? 4'(m_beat[k] * lanes_of(k)) : 4'd0;
        chk($sformatf("dut%0d_valid", k), 128'(valid_w[k]), 128'(m_active[k]));
        chk($sformatf("dut%0d_busy", k),  128'(busy_w[k]),  128'(m_active[k]));
        chk($sformatf("dut%0d_done", k),  128'(done_w[k]),  128'(m_done[k]));
        chk($sformatf("dut%0d_data", k),  data_w[k], ed);
        chk($sformatf("dut%0d_addr", k),  128'(addr_w[k]), 128'(ea));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] FIPS_SUB = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

  initial begin
    for (int k = 0; k < 3; k++) begin
      mode_v[k] = MODE_ENC;
      din_v[k]  = '0;
      m_beat[k] = 0;
      m_state[k] = '0;
    end
    build_tables();
    chk("tab_fwd_00", 128'(fwd_tab[8'h00]), 128'h63);
    chk("tab_fwd_53", 128'(fwd_tab[8'h53]), 128'hed);
    chk("tab_fwd_19", 128'(fwd_tab[8'h19]), 128'hd4);
    chk("tab_inv_d4", 128'(inv_tab[8'hd4]), 128'h19);

    rst = 1'b1;
    step(); step();
    chk("rst_valid", 128'(valid_w[0]), 128'h0);
    chk("rst_data",  data_w[0], 128'h0);
    chk("rst_busy",  128'(busy_w), 128'h0);
    rst = 1'b0;
    step();

    // FIPS-197 encrypt, LANES=4, ready high
    din_v[0] = FIPS_IN; mode_v[0] = MODE_ENC; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    step(); start_v[0] = 1'b0;
    chk("fips_b0", data_w[0], 128'hae1127d4); chk("fips_a0", 128'(addr_w[0]), 128'd0);
    step(); chk("fips_b1", data_w[0], 128'hf198bfe0); chk("fips_a1", 128'(addr_w[0]), 128'd4);
    step(); chk("fips_b2", data_w[0], 128'he55db4b8); chk("fips_a2", 128'(addr_w[0]), 128'd8);
    step(); chk("fips_b3", data_w[0], 128'h3052411e); chk("fips_a3", 128'(addr_w[0]), 128'd12);
    chk("fips_nodone", 128'(done_w[0]), 128'h0);
    step(); chk("fips_done", 128'(done_w[0]), 128'h1); chk("fips_idle", 128'(valid_w[0]), 128'h0);
    step(); chk("fips_done_once", 128'(done_w[0]), 128'h0);

    // Decrypt, LANES=16
    din_v[1] = FIPS_SUB; mode_v[1] = MODE_DEC; ready_v[1] = 1'b1; start_v[1] = 1'b1;
    step(); start_v[1] = 1'b0;
    chk("dec_data", data_w[1], FIPS_IN); chk("dec_addr", 128'(addr_w[1]), 128'd0);
    step(); chk("dec_done", 128'(done_w[1]), 128'h1);

    // Backpressure on beat 1 plus input change mid-operation
    din_v[0] = FIPS_IN; mode_v[0] = MODE_ENC; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    step(); start_v[0] = 1'b0;
    step(); ready_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", data_w[0], 128'hf198bfe0);
      chk("bp_hold_addr", 128'(addr_w[0]), 128'd4);
      din_v[0] = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    ready_v[0] = 1'b1;
    chk("bp_release", data_w[0], 128'hf198bfe0);
    step(); chk("bp_b2", data_w[0], 128'he55db4b8);
    step(); step(); chk("bp_done", 128'(done_w[0]), 128'h1);

    // Abort at beat 2, then start with all-zero data
    din_v[0] = FIPS_IN; start_v[0] = 1'b1;
    step(); start_v[0] = 1'b0;
    step(); step(); abort_v[0] = 1'b1;
    step(); abort_v[0] = 1'b0;
    chk("abort_valid", 128'(valid_w[0]), 128'h0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_nodone", 128'(done_w[0]), 128'h0);
      step();
    end
    din_v[0] = '0; start_v[0] = 1'b1;
    step(); start_v[0] = 1'b0;
    chk("zero_b0", data_w[0], 128'h63636363);
    step(); step(); step(); step();

    // Reset mid-beat
    din_v[0] = FIPS_IN; start_v[0] = 1'b1;
    step(); start_v[0] = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk("midrst_valid", 128'(valid_w[0]), 128'h0);
    chk("midrst_data",  data_w[0], 128'h0);
    chk("midrst_addr",  128'(addr_w[0]), 128'h0);
    step(); chk("midrst_nodone", 128'(done_w[0]), 128'h0);

    // Back-to-back with start held, LANES=8
    din_v[2] = FIPS_IN; mode_v[2] = MODE_ENC; ready_v[2] = 1'b1; start_v[2] = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("b2b_valid", 128'(valid_w[2]), (i % 3 == 2) ? 128'h0 : 128'h1);
      chk("b2b_done",  128'(done_w[2]),  (i % 3 == 2) ? 128'h1 : 128'h0);
      step();
    end
    start_v[2] = 1'b0;
    step(); step(); step();

    // Randomized traffic on all three configurations
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        start_v[k] = ($urandom_range(2) == 0);
        abort_v[k] = ($urandom_range(15) == 0);
        ready_v[k] = ($urandom_range(3) != 0);
        mode_v[k]  = $urandom_range(1) ? MODE_DEC : MODE_ENC;
        din_v[k]   = {$urandom, $urandom, $urandom, $urandom};
      end
      rst = ($urandom_range(249) == 0);
      step();
    end
    rst = 1'b0; start_v = '0; abort_v = '0; ready_v = '1;
    for (int i = 0; i < 5; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes128_sub_bytes_lanes.md
# aes128_sub_bytes_lanes

Multi-lane SubBytes engine for the AES-128 datapath. It snapshots a full state on `start_i` and streams S-box-substituted bytes out, `LANES` bytes per beat, with downstream backpressure and abort. It supports forward and inverse S-box selection. It sits between the state register and the ShiftRows/write-back stage, replacing the single-byte, no-backpressure SubBytes stepper.

## Interface
Parameters:
- `N_BYTES`, default 16: bytes per state; must be a multiple of `LANES`.
- `LANES`, default 4: bytes substituted per beat; one of 1, 2, 4, 8, 16.
- Derived, not overridable:
  - `BEATS` = `N_BYTES/LANES`
  - `AW` = `$clog2(N_BYTES)`

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. One clock; reset is synchronous and active-high.
- `mode_i`, in, `mode_t` (aes128_type_pkg): encrypt selects forward S-box, decrypt selects inverse. Sampled at start.
- `data_i`, in, `N_BYTES*8`: input state. Byte k is `data_i[8k+7:8k]`. Sampled at start.
- `start_i`, in, 1: start request. Accepted only in IDLE.
- `abort_i`, in, 1: cancel the current operation.
- `busy_o`, out, 1: high when not IDLE.
- `valid_o`, out, 1: beat available.
- `ready_i`, in, 1: downstream accepts the beat.
- `data_o`, out, `LANES*8`: lane j = substituted byte `addr_o+j`, at bits `[8j+7:8j]`.
- `addr_o`, out, `AW`: index of the first byte of the current beat (`beat*LANES`).
- `done_o`, out, 1: one-cycle pulse after the final beat is accepted.
- `sbox_sub_o`, out, `LANES*8`: external S-box inputs. Present only with the macro (see Configuration).
- `sbox_sub_i`, in, `LANES*8`: external S-box results. Present only with the macro (see Configuration).

## Operation
- States: IDLE, OUTPUT.
- Internal registers:
  - `snap` (`N_BYTES*8`): captured state.
  - `mode_q`: captured mode.
  - `beat` (`$clog2(BEATS)` bits, min 1): current beat index.
  - `done_q`: registered done.
- IDLE:
  - Outputs: `valid_o`=0, `addr_o`=0, `data_o`=0, `sbox_sub_o`=0.
  - On `start_i` && !`abort_i`: `snap`<=`data_i`, `mode_q`<=`mode_i`, `beat`<=0, go to OUTPUT.
- OUTPUT:
  - `valid_o`=1.
  - `addr_o`=`beat*LANES`.
  - `data_o` lane j = S(`snap` byte `beat*LANES+j`), where S is forward or inverse per `mode_q`. Combinational from registers.
- Handshake: a beat transfers on `valid_o && ready_i`. `data_o` and `addr_o` hold stable while `ready_i`=0.
- On transfer of a non-final beat: `beat`++.
- On transfer of the final beat (`beat`==`BEATS-1`): go to IDLE, `done_q`<=1. `done_o` rises in the next cycle for exactly one cycle.
- `start_i` while in OUTPUT is ignored. `snap` is not disturbed.
- `abort_i` in OUTPUT:
  - Go to IDLE next edge; `done_o` is never pulsed.
  - Abort wins over a coincident final transfer. The downstream still observed that handshake; no done follows.
- `abort_i` and `start_i` together in IDLE: start is not accepted.
- `LANES`==`N_BYTES`: single beat; `beat` is held at 0.

## Timing
- Reset values: state IDLE, `beat` 0, `done_q` 0, `snap` 0. Resulting outputs: `busy_o`=0, `valid_o`=0, `done_o`=0, `addr_o`=0, `data_o`=0, `sbox_sub_o`=0.
- Reset mid-operation: the next cycle is IDLE. No pending done survives.
- Start accepted at edge T: `valid_o`=1 in cycle T+1.
- With `ready_i` held high: `BEATS` consecutive valid cycles, then `done_o` in cycle T+1+`BEATS`.
- `done_o` is concurrent with IDLE, so `start_i` in the `done_o` cycle is accepted. Back-to-back gap is exactly one non-valid cycle.
- The S-box path is combinational, so no extra latency. With the external macro, `sbox_sub_i` must be valid in the same cycle as `sbox_sub_o`.

## Configuration
- Macro: `AES128_SUB_BYTES_EXT_SBOX_EN`.
- Defined:
  - The `sbox_sub_o`/`sbox_sub_i` ports exist.
  - `sbox_sub_o` lane j = `snap` byte `beat*LANES+j` in OUTPUT, 0 in IDLE.
  - `data_o` = `sbox_sub_i` in OUTPUT.
  - The external S-box owns mode selection; `mode_q` is not used.
- Undefined:
  - No `sbox_sub_*` ports.
  - `LANES` instances of `aes128_rijndael_sbox` are instantiated, driven by `mode_q`.

## Test plan
- FIPS-197 App. B, N_BYTES=16, LANES=4, encrypt, ready high:
  - Stimulus: `data_i` bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08.
  - Required beats, `addr_o` 0/4/8/12: d4 27 11 ae | e0 bf 98 f1 | b8 b4 5d e5 | 1e 41 52 30.
  - `done_o` in the cycle after the fourth beat.
- Decrypt, LANES=16: input = the SubBytes output above -> one beat equal to the original input (19 3d ... 08), `addr_o`=0.
- Backpressure, LANES=4:
  - `ready_i` low for 3 cycles on beat 1 -> `data_o`=e0 bf 98 f1 and `addr_o`=4 held stable for those 3 cycles.
  - `data_i` changed mid-operation -> no effect on output.
- Abort at beat 2 with `ready_i`=1 -> IDLE next cycle, `valid_o`=0, `done_o` never asserted. A following start with all-zero data -> first beat 63 63 63 63.
- Reset and back-to-back:
  - `rst_i` asserted mid-beat -> all outputs 0 next cycle.
  - `start_i` held high continuously, LANES=8 -> valid pattern 1,1,0,1,1,0, with `done_o` on each 0 cycle.
